// File: rtl/cam_pkg.sv
// Shared state encoding and default frame geometry for the camera frame reader.
package cam_pkg;

    localparam int CAM_WORD_W             = 32;
    localparam int CAM_BIT_W              = $clog2(CAM_WORD_W);
    localparam int CAM_DEF_WORDS_PER_LINE = 10;
    localparam int CAM_DEF_NUM_LINES      = 240;
    localparam int CAM_DEF_ADDR_W         = 13;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_REL,
        ST_FETCH,
        ST_LOAD,
        ST_STREAM
    } cam_state_t;

endpackage

// File: rtl/cam_word_unpacker.sv
// Serialises 32-bit RAM words LSB first, one bit per accepted beat, with a one-word prefetch slot.
// Beat is held while ready is low; the prefetched word replaces the shift register on bit 31 with no bubble.
module cam_word_unpacker
    import cam_pkg::*;
(
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  load,
    input  logic                  pf_load,
    input  logic [CAM_WORD_W-1:0] data,
    input  logic                  ready,
    output logic                  valid,
    output logic                  pix,
    output logic [CAM_BIT_W-1:0]  bit_idx,
    output logic                  word_consumed
);

    localparam logic [CAM_BIT_W-1:0] LAST_BIT = CAM_BIT_W'(CAM_WORD_W - 1);

    logic [CAM_WORD_W-1:0] shift_reg;
    logic [CAM_WORD_W-1:0] pf_reg;
    logic                  pf_valid;
    logic                  xfer;

    assign xfer          = valid && ready;
    assign word_consumed = xfer && (bit_idx == LAST_BIT);
    assign pix           = shift_reg[0];

    always_ff @(posedge clk) begin
        if (clr) begin
            shift_reg <= '0;
            pf_reg    <= '0;
            pf_valid  <= 1'b0;
            valid     <= 1'b0;
            bit_idx   <= '0;
        end else begin
            if (load) begin
                shift_reg <= data;
                valid     <= 1'b1;
                bit_idx   <= '0;
            end else if (xfer) begin
                bit_idx <= bit_idx + CAM_BIT_W'(1);
                if (bit_idx == LAST_BIT) begin
                    // An empty prefetch slot here means the frame's last word just finished.
                    shift_reg <= pf_valid ? pf_reg : '0;
                    valid     <= pf_valid;
                    pf_valid  <= 1'b0;
                end else begin
                    shift_reg <= shift_reg >> 1;
                end
            end
            if (pf_load) begin
                pf_reg   <= data;
                pf_valid <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/cam_frame_reader.sv
// Runs the capture request/done handshake, then streams the frame RAM as 1-bit pixel beats with frame/line markers.
// First beat 2 cycles after leaving REL; valid/ready backpressure holds the current beat and its markers.
module cam_frame_reader
    import cam_pkg::*;
#(
    parameter int WORDS_PER_LINE = CAM_DEF_WORDS_PER_LINE,
    parameter int NUM_LINES      = CAM_DEF_NUM_LINES,
    parameter int ADDR_W         = CAM_DEF_ADDR_W
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  START,
    input  logic                  ABORT,
    output logic                  CAP_REQ,
    input  logic                  CAP_DONE,
    output logic [ADDR_W-1:0]     RAM_RADDR,
    input  logic [CAM_WORD_W-1:0] RAM_RDATA,
    output logic                  PIX_VALID,
    input  logic                  PIX_READY,
    output logic                  PIX_DATA,
    output logic                  PIX_SOF,
    output logic                  PIX_EOF,
    output logic                  PIX_SOL,
    output logic                  PIX_EOL,
    output logic                  BUSY,
    output logic                  FRAME_DONE
);

    localparam int WIL_W  = (WORDS_PER_LINE > 1) ? $clog2(WORDS_PER_LINE) : 1;
    localparam int LINE_W = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;
    localparam logic [WIL_W-1:0]     WIL_LAST  = WIL_W'(WORDS_PER_LINE - 1);
    localparam logic [LINE_W-1:0]    LINE_LAST = LINE_W'(NUM_LINES - 1);
    localparam logic [ADDR_W-1:0]    LAST_ADDR = ADDR_W'(WORDS_PER_LINE * NUM_LINES - 1);
    localparam logic [CAM_BIT_W-1:0] LAST_BIT  = CAM_BIT_W'(CAM_WORD_W - 1);

    if (WORDS_PER_LINE < 1 || NUM_LINES < 1 || WORDS_PER_LINE * NUM_LINES > 2 ** ADDR_W) begin : g_bad_geometry
        $error("cam_frame_reader: frame geometry does not fit the RAM address space");
    end

    cam_state_t           state;
    logic [WIL_W-1:0]     wil;
    logic [LINE_W-1:0]    line;
    logic                 rd_s1;
    logic                 rd_s2;
    logic [CAM_BIT_W-1:0] bit_idx;
    logic                 word_consumed;
    logic                 sol;
    logic                 eol;
    logic                 last_line;

    // rd_s1: address on RAM_RADDR this cycle; rd_s2: its data is on RAM_RDATA this cycle.
    cam_word_unpacker u_unpacker (
        .clk           (HCLK),
        .clr           (HRESET || ABORT),
        .load          (state == ST_LOAD),
        .pf_load       (rd_s2 && (state == ST_STREAM)),
        .data          (RAM_RDATA),
        .ready         (PIX_READY),
        .valid         (PIX_VALID),
        .pix           (PIX_DATA),
        .bit_idx       (bit_idx),
        .word_consumed (word_consumed)
    );

    assign sol       = (bit_idx == '0) && (wil == '0);
    assign eol       = (bit_idx == LAST_BIT) && (wil == WIL_LAST);
    assign last_line = (line == LINE_LAST);

    assign PIX_SOL = PIX_VALID && sol;
    assign PIX_EOL = PIX_VALID && eol;
    assign PIX_SOF = PIX_VALID && sol && (line == '0);
    assign PIX_EOF = PIX_VALID && eol && last_line;
    assign BUSY    = (state != ST_IDLE);

    always_ff @(posedge HCLK) begin
        if (HRESET || ABORT) begin
            state      <= ST_IDLE;
            CAP_REQ    <= 1'b0;
            RAM_RADDR  <= '0;
            rd_s1      <= 1'b0;
            rd_s2      <= 1'b0;
            wil        <= '0;
            line       <= '0;
            FRAME_DONE <= 1'b0;
        end else begin
            rd_s1      <= 1'b0;
            rd_s2      <= rd_s1;
            FRAME_DONE <= 1'b0;
            case (state)
                ST_IDLE: if (START) begin
                    state   <= ST_REQ;
                    CAP_REQ <= 1'b1;
                end
                ST_REQ: if (CAP_DONE) begin
                    state   <= ST_REL;
                    CAP_REQ <= 1'b0;
                end
                ST_REL: if (!CAP_DONE) begin
                    state     <= ST_FETCH;
                    RAM_RADDR <= '0;
                    rd_s1     <= 1'b1;
                end
                ST_FETCH: begin
                    state <= ST_LOAD;
                    if (LAST_ADDR != '0) begin
                        RAM_RADDR <= ADDR_W'(1);
                        rd_s1     <= 1'b1;
                    end
                end
                ST_LOAD: state <= ST_STREAM;
                ST_STREAM: if (word_consumed) begin
                    if (wil == WIL_LAST) begin
                        wil  <= '0;
                        line <= last_line ? '0 : line + LINE_W'(1);
                    end else begin
                        wil <= wil + WIL_W'(1);
                    end
                    if ((wil == WIL_LAST) && last_line) begin
                        state      <= ST_IDLE;
                        FRAME_DONE <= 1'b1;
                    end else if (RAM_RADDR < LAST_ADDR) begin
                        RAM_RADDR <= RAM_RADDR + ADDR_W'(1);
                        rd_s1     <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/cam_frame_reader.md
Name: cam_frame_reader

Overview:
- Consumer side of the binarized camera frame buffer: runs the capture request/done handshake, then reads the dual-port frame RAM on its HCLK read port and streams pixels out one bit per beat.
- Pixels leave on a valid/ready stream with start-of-frame, end-of-frame, start-of-line and end-of-line markers.
- Sits between the capture block and a pixel consumer, such as an LCD/VGA bridge or a feature-extraction engine.

Parameters:
- WORDS_PER_LINE, 10, number of 32-pixel RAM words per image line (320 px)
- NUM_LINES, 240, number of lines per frame
- ADDR_W, 13, RAM read address width; WORDS_PER_LINE*NUM_LINES must be ≤ 2**ADDR_W (elaboration-time assertion)

Ports:
- HCLK  in  1  sole clock; RAM read port and capture handshake run on it
- HRESET  in  1  synchronous, active-high reset
- START  in  1  one-cycle request to acquire and stream one frame
- ABORT  in  1  synchronous abort of the current frame
- CAP_REQ  out  1  capture request; connects to capture DATA_VALID
- CAP_DONE  in  1  frame-captured flag; connects to capture DATA_READY
- RAM_RADDR  out  ADDR_W  frame RAM read address
- RAM_RDATA  in  32  RAM data for the address sampled at the previous HCLK edge; bit 0 = first pixel of the word
- PIX_VALID  out  1  pixel beat valid
- PIX_READY  in  1  consumer accepts the beat
- PIX_DATA  out  1  binarized pixel
- PIX_SOF  out  1  marks first pixel of the frame
- PIX_EOF  out  1  marks last pixel of the frame
- PIX_SOL  out  1  marks first pixel of a line
- PIX_EOL  out  1  marks last pixel of a line
- BUSY  out  1  high in every state except IDLE
- FRAME_DONE  out  1  one-cycle pulse after the last pixel is accepted

Behaviour:
- Reset values: all outputs 0, RAM_RADDR=0, FSM=IDLE, all counters 0.
- States and transitions:
  - IDLE --START--> REQ.
  - REQ (CAP_REQ=1) --CAP_DONE=1--> REL.
  - REL (CAP_REQ=0) --CAP_DONE=0--> FETCH.
  - FETCH drives RAM_RADDR=0 for one cycle, then goes to LOAD.
  - LOAD captures RAM_RDATA into the shift register, drives RAM_RADDR=1 (prefetch), then goes to STREAM.
  - STREAM --last beat accepted--> IDLE with FRAME_DONE=1 for that cycle.
- START latency: CAP_REQ rises on the cycle after START.
- Stream latency: first PIX_VALID comes exactly 2 cycles after the FSM leaves REL.
- Beat handshake:
  - A beat transfers when PIX_VALID and PIX_READY are both high.
  - Once PIX_VALID is high, PIX_DATA and all four markers stay stable until the transfer; PIX_VALID does not drop except on ABORT or HRESET.
  - PIX_VALID does not depend combinationally on PIX_READY.
- Bit unpacking:
  - PIX_DATA = shift_reg[0]; each transfer shifts the register right by 1.
  - A 5-bit bit index counts transfers and wraps 31→0.
- Prefetch:
  - The cycle after each word load, the next address is read into a prefetch register and its pf_valid flag is set.
  - The transfer of bit 31 loads the shift register from the prefetch register with no bubble; the next read is then issued.
  - A word spans at least 32 cycles, so the prefetch register is always full by bit 31.
  - No read is issued beyond address WORDS_PER_LINE*NUM_LINES-1; RAM_RADDR holds that value.
- Markers:
  - Counters: word_in_line (wraps at WORDS_PER_LINE-1) and line (0..NUM_LINES-1).
  - SOL when bit=0 and word_in_line=0.
  - EOL when bit=31 and word_in_line=WORDS_PER_LINE-1.
  - SOF = SOL and line=0.
  - EOF = EOL and line=NUM_LINES-1.
- Degenerate size: with WORDS_PER_LINE=1 and NUM_LINES=1 a beat carries SOF, SOL, EOF and EOL as appropriate, and no prefetch is issued.
- START outside IDLE is ignored. START and ABORT in the same cycle: ABORT wins and the FSM stays IDLE.
- ABORT in any state:
  - Next cycle: IDLE, CAP_REQ=0, PIX_VALID=0, and all counters cleared.
  - No FRAME_DONE is generated.
  - An in-flight beat is dropped.
- CAP_DONE already high in REQ on entry: the FSM moves to REL the next cycle.
- CAP_DONE glitching low in REQ: the FSM stays in REQ.
- HRESET mid-stream behaves as ABORT and also restores all reset values.

Decomposition:
- Shared package cam_pkg:
  - FSM state enum (IDLE, REQ, REL, FETCH, LOAD, STREAM)
  - CAM_WORD_W=32
  - default frame geometry constants
- Natural sub-module: cam_word_unpacker.
  - Owns the shift register, prefetch register with pf_valid, and the bit index.
  - Interface: load strobe/data in, beat valid/ready, word_consumed pulse out.
- The top level keeps the FSM, address generation and marker counters.

Test Plan:
- Basic frame, WORDS_PER_LINE=2, NUM_LINES=2, RAM words 0x00000001, 0x80000000, 0xFFFFFFFF, 0x0:
  - START, CAP_DONE held high 5 cycles after CAP_REQ, then low → 128 beats.
  - Beat 0 is 1 with SOF=SOL=1; beat 63 is 1 with EOL=1; beats 64–95 are all 1 with SOL at 64; beat 127 has EOF=EOL=1.
  - FRAME_DONE pulses once, the cycle after beat 127.
- Backpressure: PIX_READY random ~30% duty → identical 128-bit sequence; PIX_DATA and markers stable across every stall; no beat duplicated or lost at word boundaries (beats 31/32, 95/96).
- Full throughput: PIX_READY tied high → 128 consecutive beats with no bubble; RAM_RADDR goes 0,1,2,3 and stays at 3.
- Handshake order: CAP_DONE held high 0 cycles after CAP_REQ (already high) → REL next cycle; no RAM read until CAP_DONE has been observed low.
- ABORT at beat 40 with PIX_VALID high and PIX_READY low → next cycle PIX_VALID=0, CAP_REQ=0, BUSY=0, no FRAME_DONE; a new START streams the full 128 beats from beat 0 with SOF.
- START while streaming is ignored; HRESET=1 at beat 70 → all outputs 0 next cycle, RAM_RADDR=0.
